// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO status logic: gray decoding, full compare, depth.
package fifo_pkg;

  localparam int unsigned PTR_W = 4;
  localparam int unsigned DEPTH = 2**(PTR_W-1);
  localparam int unsigned MAX_W = 32;

  // Upper bits above w are expected to be zero, so a prefix XOR of right shifts decodes.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                input int unsigned     w);
    logic [MAX_W-1:0] b;
    b = '0;
    for (int unsigned k = 0; k < w; k++) begin
      b = b ^ (g >> k);
    end
    return b;
  endfunction

  // Full when the local pointer has lapped the remote one: top two gray bits inverted.
  function automatic logic is_full(input logic [MAX_W-1:0] l,
                                   input logic [MAX_W-1:0] s,
                                   input int unsigned      w);
    logic [MAX_W-1:0] w_mask;
    w_mask = {{(MAX_W-2){1'b0}}, 2'b11} << (w - 2);
    return l == (s ^ w_mask);
  endfunction

endpackage

// File: rtl/fifo_flag_gen_ptr_sync.sv
// Multi-flop synchroniser carrying the remote gray pointer into the local clock domain.
module ptr_sync #(
  parameter int unsigned W      = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/fifo_flag_gen.sv
// Per-domain FIFO status: synchronised remote pointer, full/empty flag, level, almost, sticky error.
module fifo_flag_gen
  import fifo_pkg::*;
#(
  parameter int unsigned n           = 4,
  parameter bit          IS_WRITE    = 1'b1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ALMOST_LVL  = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] local_ptr,
  input  logic [n-1:0] remote_ptr,
  input  logic         inc,
  input  logic         clr_err,
  output logic         flag,
  output logic [n-1:0] sync_ptr,
  output logic [n-1:0] level,
  output logic         almost,
  output logic         err_sticky
);

  logic [n-1:0] w_sync;
  logic [n-1:0] w_local_bin;
  logic [n-1:0] w_sync_bin;
  logic [n-1:0] w_level;
  logic         w_flag;
  logic         w_almost_next;
  logic         r_almost;
  logic         r_err;

  ptr_sync #(
    .W      (n),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (remote_ptr),
    .q   (w_sync)
  );

  assign w_local_bin = n'(gray2bin(MAX_W'(local_ptr), n));
  assign w_sync_bin  = n'(gray2bin(MAX_W'(w_sync), n));

  // Flag is purely combinational on registered pointers so the counter sees it on its next edge.
  assign w_flag  = IS_WRITE ? is_full(MAX_W'(local_ptr), MAX_W'(w_sync), n)
                            : (local_ptr == w_sync);
  assign w_level = IS_WRITE ? (w_local_bin - w_sync_bin) : (w_sync_bin - w_local_bin);

  assign w_almost_next = IS_WRITE ? (MAX_W'(w_level) >= ALMOST_LVL)
                                  : (MAX_W'(w_level) <= ALMOST_LVL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_almost <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_almost <= w_almost_next;
      r_err    <= (r_err & ~clr_err) | (inc & w_flag);
    end
  end

  assign flag       = w_flag;
  assign sync_ptr   = w_sync;
  assign level      = w_level;
  assign almost     = r_almost;
  assign err_sticky = r_err;

endmodule

// File: tb/tb_fifo_flag_gen.sv
// Directed bench for fifo_flag_gen: one read-side and one write-side instance on a shared clock.
module tb_fifo_flag_gen;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr_err = 1'b0;

  logic [3:0] rd_local = '0, rd_remote = '0;
  logic       rd_inc = 1'b0;
  logic       rd_flag, rd_almost, rd_err;
  logic [3:0] rd_sync, rd_level;

  logic [3:0] wr_local = '0, wr_remote = '0;
  logic       wr_inc = 1'b0;
  logic       wr_flag, wr_almost, wr_err;
  logic [3:0] wr_sync, wr_level;

  int checks = 0;
  int failures = 0;

  logic [3:0] gray_tbl [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0111, 4'b0101, 4'b0100, 4'b1100};

  always #5 clk = ~clk;

  fifo_flag_gen #(.n(4), .IS_WRITE(1'b0), .SYNC_STAGES(2), .ALMOST_LVL(6)) u_rd (
    .clk(clk), .rst(rst), .local_ptr(rd_local), .remote_ptr(rd_remote), .inc(rd_inc),
    .clr_err(clr_err), .flag(rd_flag), .sync_ptr(rd_sync), .level(rd_level),
    .almost(rd_almost), .err_sticky(rd_err));

  fifo_flag_gen #(.n(4), .IS_WRITE(1'b1), .SYNC_STAGES(2), .ALMOST_LVL(6)) u_wr (
    .clk(clk), .rst(rst), .local_ptr(wr_local), .remote_ptr(wr_remote), .inc(wr_inc),
    .clr_err(clr_err), .flag(wr_flag), .sync_ptr(wr_sync), .level(wr_level),
    .almost(wr_almost), .err_sticky(wr_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with no clock edge yet
    #2;
    chk("rst_rd_sync", 32'(rd_sync), 32'h0);
    chk("rst_rd_level", 32'(rd_level), 32'h0);
    chk("rst_rd_flag", 32'(rd_flag), 32'h1);
    chk("rst_rd_almost", 32'(rd_almost), 32'h0);
    chk("rst_rd_err", 32'(rd_err), 32'h0);
    chk("rst_wr_flag", 32'(wr_flag), 32'h0);
    chk("rst_wr_level", 32'(wr_level), 32'h0);
    chk("rst_wr_almost", 32'(wr_almost), 32'h0);
    #1;
    rst = 1'b0;

    // Sync latency on read side
    rd_remote = 4'b0001;
    step();
    chk("lat_e1_sync", 32'(rd_sync), 32'h0);
    chk("lat_e1_flag", 32'(rd_flag), 32'h1);
    step();
    chk("lat_e2_sync", 32'(rd_sync), 32'h1);
    chk("lat_e2_flag", 32'(rd_flag), 32'h0);
    chk("lat_e2_level", 32'(rd_level), 32'h1);
    chk("lat_e2_rd_almost", 32'(rd_almost), 32'h1);

    // Write side fills up with remote held at zero
    for (int i = 1; i <= 8; i++) begin
      wr_local = gray_tbl[i];
      step();
      chk("fill_level", 32'(wr_level), 32'(i));
      chk("fill_almost", 32'(wr_almost), (i >= 6) ? 32'h1 : 32'h0);
      chk("fill_flag", 32'(wr_flag), (i == int'(DEPTH)) ? 32'h1 : 32'h0);
    end

    // Sticky error: set, hold, clear, set-wins-over-clear
    chk("err_pre", 32'(wr_err), 32'h0);
    wr_inc = 1'b1;
    step();
    wr_inc = 1'b0;
    chk("err_set", 32'(wr_err), 32'h1);
    step();
    chk("err_hold", 32'(wr_err), 32'h1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("err_clr", 32'(wr_err), 32'h0);
    clr_err = 1'b1;
    wr_inc  = 1'b1;
    step();
    clr_err = 1'b0;
    wr_inc  = 1'b0;
    chk("err_set_wins", 32'(wr_err), 32'h1);

    // Wrap-around on write side
    wr_local  = 4'b1000;
    wr_remote = 4'b0100;
    step();
    step();
    chk("wrap_full_flag", 32'(wr_flag), 32'h1);
    chk("wrap_full_level", 32'(wr_level), 32'h8);
    wr_remote = 4'b1100;
    step();
    chk("wrap_e1_flag", 32'(wr_flag), 32'h1);
    step();
    chk("wrap_e2_flag", 32'(wr_flag), 32'h0);
    chk("wrap_e2_level", 32'(wr_level), 32'h7);
    chk("wrap_almost", 32'(wr_almost), 32'h1);

    // Reset mid-operation
    rd_local  = 4'b0000;
    rd_remote = 4'b0111;
    step();
    step();
    chk("mid_pre_sync", 32'(rd_sync), 32'h7);
    chk("mid_pre_level", 32'(rd_level), 32'h5);
    chk("mid_pre_err", 32'(wr_err), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_sync", 32'(rd_sync), 32'h0);
    chk("mid_rst_rd_level", 32'(rd_level), 32'h0);
    chk("mid_rst_rd_flag", 32'(rd_flag), 32'h1);
    chk("mid_rst_rd_almost", 32'(rd_almost), 32'h0);
    chk("mid_rst_wr_sync", 32'(wr_sync), 32'h0);
    chk("mid_rst_wr_almost", 32'(wr_almost), 32'h0);
    chk("mid_rst_wr_err", 32'(wr_err), 32'h0);
    chk("mid_rst_wr_level", 32'(wr_level), 32'hF);
    chk("mid_rst_wr_flag", 32'(wr_flag), 32'h0);
    #1;
    rst = 1'b0;
    step();
    chk("resume_e1_sync", 32'(rd_sync), 32'h0);
    step();
    chk("resume_e2_sync", 32'(rd_sync), 32'h7);
    chk("resume_e2_level", 32'(rd_level), 32'h5);
    chk("resume_e2_flag", 32'(rd_flag), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
